// File: rtl/frame_wr_ctrl.sv
// rtl/frame_wr_ctrl.sv - multi-buffer frame store write controller; optional FRAME_DROP_CNT_EN adds Drop_Cnt_o
module frame_wr_ctrl #(
    parameter  int ADDR_W   = 15,
    parameter  int PIXELS_P = 19200,
    parameter  int NUM_BUF  = 2,
    localparam int BUF_W    = $clog2(NUM_BUF)
) (
    input  logic                    Clk_i,
    input  logic                    Reset_i,
    input  logic                    Frame_Start_i,
    input  logic                    Pixel_Available_i,
    input  logic                    Vga_Frame_Ack_i,
    output logic [BUF_W+ADDR_W-1:0] Wr_Addr_o,
    output logic                    Wr_En_o,
    output logic                    Frame_Available_o,
    output logic [BUF_W-1:0]        Rd_Buf_Sel_o,
    output logic [BUF_W:0]          Frames_Ready_o,
`ifdef FRAME_DROP_CNT_EN
    output logic [7:0]              Drop_Cnt_o,
`endif
    output logic                    Buff_Locked_o
);

    typedef enum logic [1:0] {
        S_WAIT_SOF = 2'd0,
        S_WRITE    = 2'd1,
        S_DROP     = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_OFF = ADDR_W'(PIXELS_P - 1);
    localparam logic [BUF_W-1:0]  C_LAST_BUF = BUF_W'(NUM_BUF - 1);
    localparam logic [BUF_W:0]    C_FULL     = (BUF_W+1)'(NUM_BUF);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_offset;
    logic [BUF_W-1:0]    r_wr_buf;
    logic [BUF_W-1:0]    r_rd_buf;
    logic [BUF_W:0]      r_count;
    logic                w_wr_en;
    logic                w_complete;
    logic                w_clear_off;
    logic                w_full;
    logic                w_ack;

    assign w_full = (r_count == C_FULL);
    assign w_ack  = Vga_Frame_Ack_i && (r_count != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_complete  = 1'b0;
        w_clear_off = 1'b0;
        case (r_state)
            S_WRITE: begin
                w_wr_en = Pixel_Available_i;
                // A restart wins over completion: the pixel lands, but the frame is discarded
                if (Frame_Start_i) begin
                    w_clear_off = 1'b1;
                end else if (Pixel_Available_i && (r_offset == C_LAST_OFF)) begin
                    w_complete  = 1'b1;
                    w_clear_off = 1'b1;
                    w_state_nxt = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF, S_DROP: begin
                if (Frame_Start_i) begin
                    w_clear_off = 1'b1;
                    w_state_nxt = w_full ? S_DROP : S_WRITE;
                end
            end
            default: w_state_nxt = S_WAIT_SOF;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_state  <= S_WAIT_SOF;
            r_offset <= '0;
            r_wr_buf <= '0;
            r_rd_buf <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear_off) begin
                r_offset <= '0;
            end else if (w_wr_en) begin
                r_offset <= r_offset + 1'b1;
            end
            if (w_complete) begin
                r_wr_buf <= (r_wr_buf == C_LAST_BUF) ? '0 : r_wr_buf + 1'b1;
            end
            if (w_ack) begin
                r_rd_buf <= (r_rd_buf == C_LAST_BUF) ? '0 : r_rd_buf + 1'b1;
            end
            if (w_complete && !w_ack) begin
                r_count <= r_count + 1'b1;
            end else if (w_ack && !w_complete) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef FRAME_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic       w_enter_drop;

    assign w_enter_drop = (r_state != S_WRITE) && Frame_Start_i && w_full;

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            r_drop_cnt <= '0;
        end else if (w_enter_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign Drop_Cnt_o = r_drop_cnt;
`endif

    assign Wr_Addr_o         = {r_wr_buf, r_offset};
    assign Wr_En_o           = w_wr_en;
    assign Frame_Available_o = (r_count != '0);
    assign Buff_Locked_o     = w_full;
    assign Frames_Ready_o    = r_count;
    assign Rd_Buf_Sel_o      = r_rd_buf;

endmodule

// File: tb/tb_frame_wr_ctrl.sv
// tb/tb_frame_wr_ctrl.sv - directed bench for frame_wr_ctrl (2-buffer and 3-buffer instances)
module tb_frame_wr_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_fs = 0, a_pix = 0, a_ack = 0;
    logic [4:0] a_addr;
    logic       a_wren, a_avail, a_rdsel, a_locked;
    logic [1:0] a_ready;

    logic       b_fs = 0, b_pix = 0, b_ack = 0;
    logic [5:0] b_addr;
    logic       b_wren, b_avail, b_locked;
    logic [1:0] b_rdsel;
    logic [2:0] b_ready;

`ifdef FRAME_DROP_CNT_EN
    logic [7:0] a_drop, b_drop;
`endif

    frame_wr_ctrl #(.ADDR_W(4), .PIXELS_P(16), .NUM_BUF(2)) u_dut_a (
        .Clk_i(clk), .Reset_i(rst_n),
        .Frame_Start_i(a_fs), .Pixel_Available_i(a_pix), .Vga_Frame_Ack_i(a_ack),
        .Wr_Addr_o(a_addr), .Wr_En_o(a_wren), .Frame_Available_o(a_avail),
        .Rd_Buf_Sel_o(a_rdsel), .Frames_Ready_o(a_ready),
`ifdef FRAME_DROP_CNT_EN
        .Drop_Cnt_o(a_drop),
`endif
        .Buff_Locked_o(a_locked)
    );

    frame_wr_ctrl #(.ADDR_W(4), .PIXELS_P(16), .NUM_BUF(3)) u_dut_b (
        .Clk_i(clk), .Reset_i(rst_n),
        .Frame_Start_i(b_fs), .Pixel_Available_i(b_pix), .Vga_Frame_Ack_i(b_ack),
        .Wr_Addr_o(b_addr), .Wr_En_o(b_wren), .Frame_Available_o(b_avail),
        .Rd_Buf_Sel_o(b_rdsel), .Frames_Ready_o(b_ready),
`ifdef FRAME_DROP_CNT_EN
        .Drop_Cnt_o(b_drop),
`endif
        .Buff_Locked_o(b_locked)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic       fs, pix, ack;
        logic       wr_en;
        logic [4:0] addr;
        logic [1:0] ready;
        logic       rd_sel;
    } vec_t;
    vec_t tv[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle_a(input logic fs, input logic pix, input logic ack);
        @(negedge clk);
        a_fs = fs; a_pix = pix; a_ack = ack;
        #1;
    endtask

    task automatic cycle_b(input logic fs, input logic pix, input logic ack);
        @(negedge clk);
        b_fs = fs; b_pix = pix; b_ack = ack;
        #1;
    endtask

    task automatic frame_a(input logic buf_id, input logic wr, input logic ack_last);
        cycle_a(1'b1, 1'b0, 1'b0);
        chk("sof_wren", 32'(a_wren), 32'd0);
        for (int i = 0; i < 16; i++) begin
            cycle_a(1'b0, 1'b1, (i == 15) ? ack_last : 1'b0);
            chk("frame_wren", 32'(a_wren), 32'(wr));
            if (wr) chk("frame_addr", 32'(a_addr), 32'({buf_id, 4'(i)}));
        end
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5'h10, 2'd0, 1'b1};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h10, 2'd0, 1'b1};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h11, 2'd0, 1'b1};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h12, 2'd0, 1'b1};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h13, 2'd0, 1'b1};
        tv[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h14, 2'd0, 1'b1};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h15, 2'd0, 1'b1};
        tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h16, 2'd0, 1'b1};
        tv[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'h17, 2'd0, 1'b1};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h10, 2'd0, 1'b1};
        tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h11, 2'd0, 1'b1};
        tv[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'h11, 2'd0, 1'b1};
        tv[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h10, 2'd0, 1'b1};

        // reset state
        #1;
        chk("rst_addr", 32'(a_addr), 32'd0);
        chk("rst_wren", 32'(a_wren), 32'd0);
        chk("rst_avail", 32'(a_avail), 32'd0);
        chk("rst_rdsel", 32'(a_rdsel), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_locked", 32'(a_locked), 32'd0);
`ifdef FRAME_DROP_CNT_EN
        chk("rst_drop", 32'(a_drop), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // pixels without start-of-frame are ignored
        for (int i = 0; i < 16; i++) begin
            cycle_a(1'b0, 1'b1, 1'b0);
            chk("nosof_wren", 32'(a_wren), 32'd0);
        end
        cycle_a(1'b0, 1'b0, 1'b0);
        chk("nosof_avail", 32'(a_avail), 32'd0);

        // first two frames fill both buffers
        frame_a(1'b0, 1'b1, 1'b0);
        cycle_a(1'b0, 1'b0, 1'b0);
        chk("f1_ready", 32'(a_ready), 32'd1);
        chk("f1_avail", 32'(a_avail), 32'd1);
        chk("f1_rdsel", 32'(a_rdsel), 32'd0);
        chk("f1_locked", 32'(a_locked), 32'd0);
        frame_a(1'b1, 1'b1, 1'b0);
        cycle_a(1'b0, 1'b0, 1'b0);
        chk("f2_ready", 32'(a_ready), 32'd2);
        chk("f2_locked", 32'(a_locked), 32'd1);

        // third frame is dropped
        frame_a(1'b0, 1'b0, 1'b0);
        cycle_a(1'b0, 1'b0, 1'b0);
        chk("drop_ready", 32'(a_ready), 32'd2);
`ifdef FRAME_DROP_CNT_EN
        chk("drop_cnt", 32'(a_drop), 32'd1);
`endif
        cycle_a(1'b0, 1'b0, 1'b1);
        cycle_a(1'b0, 1'b0, 1'b0);
        chk("ack1_rdsel", 32'(a_rdsel), 32'd1);
        chk("ack1_ready", 32'(a_ready), 32'd1);
        chk("ack1_locked", 32'(a_locked), 32'd0);
        frame_a(1'b0, 1'b1, 1'b0);
        cycle_a(1'b0, 1'b0, 1'b1);
        cycle_a(1'b0, 1'b0, 1'b1);
        cycle_a(1'b0, 1'b0, 1'b0);
        chk("drain_ready", 32'(a_ready), 32'd0);
        chk("drain_rdsel", 32'(a_rdsel), 32'd1);

        // restart mid-frame, ack with nothing queued
        for (int k = 0; k < 13; k++) begin
            cycle_a(tv[k].fs, tv[k].pix, tv[k].ack);
            chk($sformatf("tv%0d_wren", k), 32'(a_wren), 32'(tv[k].wr_en));
            chk($sformatf("tv%0d_addr", k), 32'(a_addr), 32'(tv[k].addr));
            chk($sformatf("tv%0d_ready", k), 32'(a_ready), 32'(tv[k].ready));
            chk($sformatf("tv%0d_rdsel", k), 32'(a_rdsel), 32'(tv[k].rd_sel));
        end

        // finish that frame, then complete the next frame together with an ack
        for (int i = 1; i < 16; i++) begin
            cycle_a(1'b0, 1'b1, 1'b0);
            chk("rest_addr", 32'(a_addr), 32'({1'b1, 4'(i)}));
        end
        cycle_a(1'b0, 1'b0, 1'b0);
        chk("rest_ready", 32'(a_ready), 32'd1);
        chk("rest_rdsel", 32'(a_rdsel), 32'd1);
        frame_a(1'b0, 1'b1, 1'b1);
        cycle_a(1'b0, 1'b0, 1'b0);
        chk("coinc_ready", 32'(a_ready), 32'd1);
        chk("coinc_rdsel", 32'(a_rdsel), 32'd0);
        frame_a(1'b1, 1'b1, 1'b0);
        cycle_a(1'b0, 1'b0, 1'b0);
        chk("coinc2_ready", 32'(a_ready), 32'd2);
        chk("coinc2_locked", 32'(a_locked), 32'd1);

        // three buffers: six acked frames cycle 0,1,2,0,1,2
        for (int f = 0; f < 6; f++) begin
            cycle_b(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 16; i++) begin
                cycle_b(1'b0, 1'b1, 1'b0);
                chk("b_wren", 32'(b_wren), 32'd1);
                chk("b_addr", 32'(b_addr), 32'({2'(f % 3), 4'(i)}));
            end
            cycle_b(1'b0, 1'b0, 1'b1);
            chk("b_ready", 32'(b_ready), 32'd1);
            chk("b_rdsel", 32'(b_rdsel), 32'(f % 3));
            cycle_b(1'b0, 1'b0, 1'b0);
            chk("b_drained", 32'(b_ready), 32'd0);
            chk("b_rdsel_adv", 32'(b_rdsel), 32'((f + 1) % 3));
        end

        // asynchronous reset in the middle of a frame
        cycle_b(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle_b(1'b0, 1'b1, 1'b0);
        chk("pre_rst_wren", 32'(b_wren), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_b_wren", 32'(b_wren), 32'd0);
        chk("arst_b_addr", 32'(b_addr), 32'd0);
        chk("arst_b_rdsel", 32'(b_rdsel), 32'd0);
        chk("arst_a_ready", 32'(a_ready), 32'd0);
        chk("arst_a_locked", 32'(a_locked), 32'd0);
        chk("arst_a_avail", 32'(a_avail), 32'd0);
        chk("arst_a_addr", 32'(a_addr), 32'd0);
`ifdef FRAME_DROP_CNT_EN
        chk("arst_a_drop", 32'(a_drop), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        cycle_b(1'b0, 1'b1, 1'b0);
        chk("post_rst_wren", 32'(b_wren), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
